axi4lite_reg_slave: RTL
=======================

# axi4lite_reg_slave

Synthesizable AXI4-Lite responder with an on-chip register file. It is the RTL counterpart to the AXI4-Lite master BFM and sits between the AXI4-Lite fabric and a block's control/status registers. Software-writable registers are exposed as flat outputs with per-register write pulses. Registers marked read-only return hardware status inputs.

## Interface
- N, 4: data bus width in bytes; legal values 4 or 8.
- BASE_ADDR, 32'h0: byte address of register 0.
- NUM_REGS, 16: number of N-byte registers; 1..256.
- RO_MASK, {NUM_REGS{1'b0}}: bit i set means register i is read-only.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous and active-high.
- AWVALID/AWREADY  in/out  1  write-address handshake.
- AWADDR  in  32, AWPROT  in  3  write address and protection (AWPROT ignored).
- WVALID/WREADY  in/out  1  write-data handshake.
- WDATA  in  8N, WSTRB  in  N  write data and byte enables.
- BVALID/BREADY  out/in  1, BRESP  out  2  write response.
- ARVALID/ARREADY  in/out  1, ARADDR  in  32, ARPROT  in  3  read address (ARPROT ignored).
- RVALID/RREADY  out/in  1, RDATA  out  8N, RRESP  out  2  read data.
- regs_o  out  NUM_REGS*8N  current register contents; register i at [i*8N +: 8N].
- wr_pulse_o  out  NUM_REGS  one-cycle strobe when register i commits a write.
- status_i  in  NUM_REGS*8N  values returned for read-only registers.

## Operation
- Address decode:
  - offset = addr - BASE_ADDR (32-bit wrap), with the low log2(N) bits cleared.
  - index = offset / N.
  - offset >= NUM_REGS*N gives DECERR (2'b11).
  - Unaligned low address bits are ignored.
- Write FSM, states WR_IDLE and WR_RESP:
  - WR_IDLE: AWREADY = 1 until AW is captured; WREADY = 1 until W is captured. AW and W are captured independently, in either order or in the same cycle.
  - Once both are held, commit on the next edge:
    - In range and writable: apply WSTRB byte-wise to register index, pulse wr_pulse_o[index], BRESP = OKAY (2'b00).
    - In range and RO_MASK set: no update, no pulse, BRESP = SLVERR (2'b10).
    - Out of range: no update, BRESP = DECERR.
  - Go to WR_RESP with BVALID = 1, and drop both holds.
  - WR_RESP: hold BVALID and BRESP stable until BREADY; on the handshake, BVALID = 0 and go to WR_IDLE.
- Read FSM, states RD_IDLE and RD_DATA:
  - RD_IDLE: ARREADY = 1.
  - On the AR handshake, register RDATA/RRESP:
    - Writable register: register value.
    - Read-only register: status_i slice sampled that edge.
    - Out of range: 0 with DECERR.
  - Set RVALID = 1 and go to RD_DATA.
  - RD_DATA: ARREADY = 0; hold RVALID, RDATA and RRESP until RREADY; then go to RD_IDLE.
- The read and write FSMs are fully independent.

## Timing
- Reset values:
  - All READY and VALID outputs = 0.
  - BRESP, RRESP, RDATA = 0.
  - All registers in regs_o = 0; wr_pulse_o = 0.
  - Both FSMs in IDLE; AW and W holds cleared.
- ARREADY, AWREADY and WREADY go to 1 on the first edge after ARESET deasserts.
- Write latency:
  - BVALID rises exactly 1 cycle after the later of the AW and W handshakes.
  - regs_o update and wr_pulse_o appear in that same cycle.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Throughput: at most one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held high.
- Simultaneous AR capture and write commit to the same register: the read returns the pre-write value.
- Ready signals never depend combinationally on VALID inputs; all outputs are registered.
- ARESET mid-transaction: an immediate return to reset values on the next edge. An in-flight response is dropped and a partially captured AW/W is discarded.

## Structure
- Package axi4lite_pkg holds:
  - Response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - Enums wr_state_t {WR_IDLE, WR_RESP} and rd_state_t {RD_IDLE, RD_DATA}.
- Sub-module axi4lite_addr_decode is purely combinational, parameterized N/BASE_ADDR/NUM_REGS. It maps addr to index plus an in_range flag, and is instantiated once per channel.

## Test plan
- Reset then idle, N=4, BASE_ADDR=32'h1000:
  - During ARESET: all outputs 0.
  - 1 cycle after release: AWREADY = WREADY = ARREADY = 1.
- Write then read back:
  - Stimulus: write 32'hDEADBEEF with WSTRB 4'hF to 32'h1008, with AW and W in the same cycle.
  - Write response: BVALID next cycle, BRESP = 00, wr_pulse_o[2] high for 1 cycle.
  - Read 32'h1008: RVALID 1 cycle after AR, RDATA = 32'hDEADBEEF, RRESP = 00.
- Partial strobe and ordering:
  - Stimulus: W (32'h11223344, WSTRB 4'b0101) arrives 3 cycles before AW to 32'h1008.
  - Register 2 becomes 32'hDE22BE44.
  - BVALID is 1 cycle after AW.
- Errors, NUM_REGS=16, RO_MASK bit 3 set:
  - Write 32'h1040 gives DECERR; read 32'h0FFC gives DECERR with RDATA 0.
  - Write 32'h100C gives SLVERR and no pulse; read 32'h100C returns status_i[3].
- Backpressure:
  - Stimulus: hold BREADY and RREADY low for 5 cycles.
  - BVALID/BRESP and RVALID/RDATA stay stable; AWREADY, WREADY and ARREADY stay 0 until the handshake.
  - Concurrent read and write both complete.
- Reset mid-operation:
  - Stimulus: assert ARESET while BVALID = 1 after a write of register 1.
  - Next edge: BVALID = 0 and regs_o all 0.
  - A new transaction after release behaves normally.

Source files
------------

// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4lite_pkg
// Shared AXI4-Lite response codes, channel FSM state types and helpers.
// Revision: 1.0
// ---------------------------------------------------------------------------
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Register index width; a single-register file still needs one bit.
    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_addr_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4lite_addr_decode
// Maps a byte address to a register index and an in-range flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi4lite_addr_decode
    import axi4lite_pkg::*;
#(
    parameter int          N         = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          NUM_REGS  = 16
) (
    input  logic [31:0]                      addr,
    output logic [idx_width(NUM_REGS)-1:0]   index,
    output logic                             in_range
);

    localparam int c_LB = $clog2(N);
    localparam int c_IW = idx_width(NUM_REGS);

    logic [31:0] w_offset;
    logic [31:0] w_word;

    // Offsets below BASE_ADDR wrap to huge values and fall out of range.
    assign w_offset = addr - BASE_ADDR;
    assign w_word   = w_offset >> c_LB;
    assign in_range = (w_word < 32'(NUM_REGS));
    assign index    = w_word[c_IW-1:0];

endmodule
`default_nettype wire

// File: rtl/axi4lite_reg_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4lite_reg_slave
// AXI4-Lite responder over a flat register file with read-only status slots.
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int                  N         = 4,
    parameter logic [31:0]         BASE_ADDR = 32'h0,
    parameter int                  NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}}
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [31:0]                 AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        WVALID,
    output logic                        WREADY,
    input  logic [8*N-1:0]              WDATA,
    input  logic [N-1:0]                WSTRB,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic [1:0]                  BRESP,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [31:0]                 ARADDR,
    input  logic [2:0]                  ARPROT,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [8*N-1:0]              RDATA,
    output logic [1:0]                  RRESP,
    output logic [NUM_REGS*8*N-1:0]     regs_o,
    output logic [NUM_REGS-1:0]         wr_pulse_o,
    input  logic [NUM_REGS*8*N-1:0]     status_i
);

    localparam int c_DW = 8 * N;
    localparam int c_IW = idx_width(NUM_REGS);

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t           r_wr_state;
    wr_state_t           w_wr_state_nxt;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_aw_held;
    logic                r_w_held;
    logic [31:0]         r_awaddr;
    logic [c_DW-1:0]     r_wdata;
    logic [N-1:0]        r_wstrb;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_commit;
    logic                w_aw_held_nxt;
    logic                w_w_held_nxt;
    logic                w_awready_nxt;
    logic                w_wready_nxt;
    logic                w_bvalid_nxt;
    logic [1:0]          w_bresp_nxt;

    logic [c_IW-1:0]     w_wr_idx;
    logic                w_wr_in_range;
    logic                w_wr_ro;
    logic [NUM_REGS-1:0] w_we;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t           r_rd_state;
    rd_state_t           w_rd_state_nxt;
    logic                r_arready;
    logic                r_rvalid;
    logic [c_DW-1:0]     r_rdata;
    logic [1:0]          r_rresp;

    logic                w_ar_hs;
    logic                w_arready_nxt;
    logic                w_rvalid_nxt;
    logic [c_DW-1:0]     w_rdata_nxt;
    logic [1:0]          w_rresp_nxt;

    logic [c_IW-1:0]     w_rd_idx;
    logic                w_rd_in_range;
    logic [c_DW-1:0]     w_rd_val;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [c_DW-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;

    // Protection bits carry no meaning here; status of writable slots is unused.
    logic w_unused;
    assign w_unused = ^{AWPROT, ARPROT, status_i};

    axi4lite_addr_decode #(
        .N         (N),
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_wr_dec (
        .addr      (r_awaddr),
        .index     (w_wr_idx),
        .in_range  (w_wr_in_range)
    );

    axi4lite_addr_decode #(
        .N         (N),
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_rd_dec (
        .addr      (ARADDR),
        .index     (w_rd_idx),
        .in_range  (w_rd_in_range)
    );

    assign w_aw_hs  = AWVALID && r_awready;
    assign w_w_hs   = WVALID && r_wready;
    assign w_commit = (r_wr_state == WR_IDLE) && r_aw_held && r_w_held;
    assign w_ar_hs  = ARVALID && r_arready;

    // Write FSM: state and registered outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
        end
    end

    // Write FSM: next state
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (w_commit)            w_wr_state_nxt = WR_RESP;
            WR_RESP: if (BREADY && r_bvalid)  w_wr_state_nxt = WR_IDLE;
            default:                          w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // Write FSM: next values of the registered outputs
    always_comb begin
        w_aw_held_nxt = (r_aw_held || w_aw_hs) && !w_commit;
        w_w_held_nxt  = (r_w_held  || w_w_hs)  && !w_commit;
        w_awready_nxt = (w_wr_state_nxt == WR_IDLE) && !w_aw_held_nxt;
        w_wready_nxt  = (w_wr_state_nxt == WR_IDLE) && !w_w_held_nxt;
        w_bvalid_nxt  = (w_wr_state_nxt == WR_RESP);
        w_bresp_nxt   = r_bresp;
        if (w_commit) begin
            if (!w_wr_in_range) begin
                w_bresp_nxt = RESP_DECERR;
            end else if (w_wr_ro) begin
                w_bresp_nxt = RESP_SLVERR;
            end else begin
                w_bresp_nxt = RESP_OKAY;
            end
        end
    end

    // Captured AW and W payloads, held until the commit
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= AWADDR;
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
        end
    end

    // Per-register lookups for both channels
    always_comb begin
        w_wr_ro  = 1'b0;
        w_rd_val = '0;
        w_we     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_idx == c_IW'(i)) begin
                w_wr_ro = RO_MASK[i];
            end
            if (w_rd_idx == c_IW'(i)) begin
                w_rd_val = RO_MASK[i] ? status_i[i*c_DW +: c_DW] : r_regs[i];
            end
            w_we[i] = w_commit && w_wr_in_range && (w_wr_idx == c_IW'(i)) && !RO_MASK[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= w_we;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < N; b++) begin
                    if (w_we[i] && r_wstrb[b]) begin
                        r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read FSM: state and registered outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
        end
    end

    // Read FSM: next state
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_ar_hs)             w_rd_state_nxt = RD_DATA;
            RD_DATA: if (RREADY && r_rvalid)  w_rd_state_nxt = RD_IDLE;
            default:                          w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM: next values; register reads see the pre-commit contents
    always_comb begin
        w_arready_nxt = (w_rd_state_nxt == RD_IDLE);
        w_rvalid_nxt  = (w_rd_state_nxt == RD_DATA);
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        if (w_ar_hs) begin
            w_rdata_nxt = w_rd_in_range ? w_rd_val : '0;
            w_rresp_nxt = w_rd_in_range ? RESP_OKAY : RESP_DECERR;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
        assign regs_o[gi*c_DW +: c_DW] = r_regs[gi];
    end

    assign AWREADY    = r_awready;
    assign WREADY     = r_wready;
    assign BVALID     = r_bvalid;
    assign BRESP      = r_bresp;
    assign ARREADY    = r_arready;
    assign RVALID     = r_rvalid;
    assign RDATA      = r_rdata;
    assign RRESP      = r_rresp;
    assign wr_pulse_o = r_wr_pulse;

endmodule
`default_nettype wire
